// File: rtl/core_pkg.sv
// core_pkg: control-bundle widths, bit positions and write-back encodings shared by the RV32I pipeline.
package core_pkg;
    localparam int EX_W = 5;
    localparam int M_W  = 3;
    localparam int WB_W = 3;
    localparam int WB_REG_WRITE = 2;
    localparam int M_MEM_WRITE  = 0;
    localparam int M_BRANCH     = 2;
    localparam int EX_ALU_SRC_B = 4;
    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_IMM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;
    localparam logic [1:0] MTR_MEM = 2'b11;
    localparam logic [WB_W-1:0] WB_LOAD = {1'b1, MTR_MEM};
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of the load currently in EX.
module load_use_detect
    import core_pkg::*;
(
    input  logic            ex_valid,
    input  logic [WB_W-1:0] ex_wb,
    input  logic [4:0]      ex_rd_addr,
    input  logic            id_valid,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    output logic            load_use
);
    logic rs1_hit, rs2_hit;
    assign rs1_hit  = id_uses_rs1 & (id_rs1_addr == ex_rd_addr);
    assign rs2_hit  = id_uses_rs2 & (id_rs2_addr == ex_rd_addr);
    assign load_use = ex_valid & (ex_wb == WB_LOAD) & (ex_rd_addr != 5'd0) & id_valid & (rs1_hit | rs2_hit);
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with load-use stall, flush bubbles and a saturating bubble counter.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [EX_W-1:0]  id_ex,
    input  logic [M_W-1:0]   id_m,
    input  logic [WB_W-1:0]  id_wb,
    input  logic             ex_flush,
    input  logic             ext_stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1_addr,
    output logic [4:0]       ex_rs2_addr,
    output logic [4:0]       ex_rd_addr,
    output logic [EX_W-1:0]  ex_ex,
    output logic [M_W-1:0]   ex_m,
    output logic [WB_W-1:0]  ex_wb,
    output logic             hz_stall,
    output logic [CNT_W-1:0] bubble_cnt
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [EX_W-1:0] ex;
        logic [M_W-1:0]  m;
        logic [WB_W-1:0] wb;
    } ex_reg_t;

    ex_reg_t          ex_q, ex_d, id_bundle;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use, bubble;

    load_use_detect u_load_use_detect (
        .ex_valid    (ex_q.valid),
        .ex_wb       (ex_q.wb),
        .ex_rd_addr  (ex_q.rd_addr),
        .id_valid    (id_valid),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .load_use    (load_use)
    );

    // A flushed ID instruction is wrong-path, so it is killed rather than stalled.
    assign hz_stall  = load_use & ~ex_flush;
    assign bubble    = ex_flush | load_use;
    assign id_bundle = '{valid: id_valid, pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data,
                         imm: id_imm, rs1_addr: id_rs1_addr, rs2_addr: id_rs2_addr,
                         rd_addr: id_rd_addr, ex: id_ex, m: id_m, wb: id_wb};

    always_comb begin
        ex_d  = ext_stall ? ex_q : bubble ? '0 : id_bundle;
        cnt_d = (ext_stall | ~bubble | (&cnt_q)) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_pc       = ex_q.pc;
    assign ex_rs1_data = ex_q.rs1_data;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_imm      = ex_q.imm;
    assign ex_rs1_addr = ex_q.rs1_addr;
    assign ex_rs2_addr = ex_q.rs2_addr;
    assign ex_rd_addr  = ex_q.rd_addr;
    assign ex_ex       = ex_q.ex;
    assign ex_m        = ex_q.m;
    assign ex_wb       = ex_q.wb;
    assign bubble_cnt  = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors with a scoreboard queue checked by an independent monitor.
module tb_id_ex_stage;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [4:0]  ex;
        logic [2:0]  m;
        logic [2:0]  wb;
    } st_t;
    typedef struct packed {
        st_t         s;
        logic [15:0] c;
        logic [1:0]  c2;
    } exp_t;

    localparam int CAP = 0, BUB = 1, HOLD = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        id_valid = 1'b0, id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0, id_ex = '0;
    logic [2:0]  id_m = '0, id_wb = '0;
    logic        ex_flush = 1'b0, ext_stall = 1'b0;

    logic        ex_valid, hz_stall, ex_valid2, hz_stall2;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [31:0] ex_pc2, ex_rs1_data2, ex_rs2_data2, ex_imm2;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_ex;
    logic [4:0]  ex_rs1_addr2, ex_rs2_addr2, ex_rd_addr2, ex_ex2;
    logic [2:0]  ex_m, ex_wb, ex_m2, ex_wb2;
    logic [15:0] bubble_cnt;
    logic [1:0]  bubble_cnt2;
    st_t         obs1, obs2;

    int   tests = 0, fails = 0, step_n = 0;
    st_t  ms = '0;
    logic [15:0] mc = '0;
    logic [1:0]  mc2 = '0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_ex(id_ex), .id_m(id_m), .id_wb(id_wb), .ex_flush(ex_flush), .ext_stall(ext_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
        .ex_ex(ex_ex), .ex_m(ex_m), .ex_wb(ex_wb), .hz_stall(hz_stall), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.XLEN(32), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_ex(id_ex), .id_m(id_m), .id_wb(id_wb), .ex_flush(ex_flush), .ext_stall(ext_stall),
        .ex_valid(ex_valid2), .ex_pc(ex_pc2), .ex_rs1_data(ex_rs1_data2), .ex_rs2_data(ex_rs2_data2),
        .ex_imm(ex_imm2), .ex_rs1_addr(ex_rs1_addr2), .ex_rs2_addr(ex_rs2_addr2), .ex_rd_addr(ex_rd_addr2),
        .ex_ex(ex_ex2), .ex_m(ex_m2), .ex_wb(ex_wb2), .hz_stall(hz_stall2), .bubble_cnt(bubble_cnt2)
    );

    assign obs1 = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr, ex_rs2_addr,
                   ex_rd_addr, ex_ex, ex_m, ex_wb};
    assign obs2 = {ex_valid2, ex_pc2, ex_rs1_data2, ex_rs2_data2, ex_imm2, ex_rs1_addr2, ex_rs2_addr2,
                   ex_rd_addr2, ex_ex2, ex_m2, ex_wb2};

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s (step %0d): got %h required %h", name, step_n, got, want);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] rd, input logic u1, input logic u2, input logic [4:0] exb,
                          input logic [2:0] mb, input logic [2:0] wbb);
        id_valid = v; id_pc = pc; id_rs1_addr = a1; id_rs2_addr = a2; id_rd_addr = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_ex = exb; id_m = mb; id_wb = wbb;
        id_rs1_data = pc * 3 + 1; id_rs2_data = ~pc; id_imm = pc + 32'h40;
    endtask

    // Check hz_stall for the vector now on the inputs, queue the hand-classified next EX state, advance one cycle.
    task automatic cyc(input int kind, input logic hz_exp);
        #1;
        chk("hz_stall", 160'(hz_stall), 160'(hz_exp));
        chk("hz_stall_cnt2", 160'(hz_stall2), 160'(hz_exp));
        if (kind == CAP)
            ms = {id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1_addr, id_rs2_addr,
                  id_rd_addr, id_ex, id_m, id_wb};
        else if (kind == BUB) begin
            ms  = '0;
            mc  = (mc == 16'hFFFF) ? mc : mc + 16'd1;
            mc2 = (mc2 == 2'd3) ? mc2 : mc2 + 2'd1;
        end
        sbq.push_back('{s: ms, c: mc, c2: mc2});
        @(negedge clk);
        step_n++;
    endtask

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("ex_state", 160'(obs1), 160'(e.s));
            chk("bubble_cnt", 160'(bubble_cnt), 160'(e.c));
            chk("ex_state_cnt2", 160'(obs2), 160'(e.s));
            chk("bubble_cnt_sat", 160'(bubble_cnt2), 160'(e.c2));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_state", 160'(obs1), 160'(0));
        chk("reset_cnt", 160'(bubble_cnt), 160'(0));
        chk("reset_hz", 160'(hz_stall), 160'(0));
        @(negedge clk);
        // lw x5 then add x6,x5,x7: one bubble, then add captured
        set_id(1, 32'h100, 5'd2, 5'd0, 5'd5, 1, 0, 5'b10000, 3'b000, 3'b111); cyc(CAP, 0);
        set_id(1, 32'h104, 5'd5, 5'd7, 5'd6, 1, 1, 5'b00000, 3'b000, 3'b100); cyc(BUB, 1);
        cyc(CAP, 0);
        // load to x0 then consumer of x0
        set_id(1, 32'h108, 5'd1, 5'd0, 5'd0, 1, 0, 5'b10000, 3'b000, 3'b111); cyc(CAP, 0);
        set_id(1, 32'h10C, 5'd0, 5'd3, 5'd4, 1, 1, 5'b00001, 3'b000, 3'b100); cyc(CAP, 0);
        // flush coincides with load-use: one bubble only, no stall
        set_id(1, 32'h110, 5'd1, 5'd0, 5'd8, 1, 0, 5'b10000, 3'b000, 3'b111); cyc(CAP, 0);
        set_id(1, 32'h114, 5'd3, 5'd8, 5'd9, 1, 1, 5'b10000, 3'b001, 3'b000);
        ex_flush = 1'b1; cyc(BUB, 0); ex_flush = 1'b0;
        // back-to-back loads, consumer of the older load does not stall
        set_id(1, 32'h118, 5'd1, 5'd0, 5'd9, 1, 0, 5'b10000, 3'b000, 3'b111); cyc(CAP, 0);
        set_id(1, 32'h11C, 5'd3, 5'd0, 5'd10, 1, 0, 5'b10000, 3'b000, 3'b111); cyc(CAP, 0);
        set_id(1, 32'h120, 5'd9, 5'd11, 5'd12, 1, 1, 5'b00010, 3'b000, 3'b100); cyc(CAP, 0);
        // invalid ID instruction never stalls
        set_id(1, 32'h124, 5'd1, 5'd0, 5'd13, 1, 0, 5'b10000, 3'b000, 3'b111); cyc(CAP, 0);
        set_id(0, 32'h128, 5'd13, 5'd0, 5'd14, 1, 0, 5'b00000, 3'b000, 3'b100); cyc(CAP, 0);
        // rs2 match without uses_rs2 does not stall
        set_id(1, 32'h12C, 5'd1, 5'd0, 5'd14, 1, 0, 5'b10000, 3'b000, 3'b111); cyc(CAP, 0);
        set_id(1, 32'h130, 5'd1, 5'd14, 5'd15, 1, 0, 5'b00011, 3'b100, 3'b100); cyc(CAP, 0);
        // ext_stall freezes everything for 3 cycles while ID changes
        set_id(1, 32'h134, 5'd1, 5'd0, 5'd15, 1, 0, 5'b10000, 3'b000, 3'b111); cyc(CAP, 0);
        ext_stall = 1'b1;
        set_id(1, 32'h138, 5'd15, 5'd0, 5'd16, 1, 0, 5'b00000, 3'b000, 3'b100); cyc(HOLD, 1);
        set_id(1, 32'h13C, 5'd15, 5'd2, 5'd17, 1, 1, 5'b00100, 3'b000, 3'b100); cyc(HOLD, 1);
        set_id(1, 32'h140, 5'd3, 5'd4, 5'd18, 1, 1, 5'b00101, 3'b000, 3'b100); cyc(HOLD, 0);
        ext_stall = 1'b0;
        set_id(1, 32'h200, 5'd3, 5'd4, 5'd19, 1, 1, 5'b00110, 3'b000, 3'b100); cyc(CAP, 0);
        // async reset mid-cycle with a valid EX entry
        #2 rst = 1'b1;
        #1;
        chk("async_reset_state", 160'(obs1), 160'(0));
        chk("async_reset_cnt", 160'(bubble_cnt), 160'(0));
        chk("async_reset_hz", 160'(hz_stall), 160'(0));
        @(negedge clk);
        rst = 1'b0; ms = '0; mc = '0; mc2 = '0;
        set_id(1, 32'h300, 5'd1, 5'd2, 5'd3, 1, 1, 5'b00111, 3'b010, 3'b100); cyc(CAP, 0);
        // consecutive flushes: 16-bit counter 1..5, 2-bit counter saturates at 3
        ex_flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_id(1, 32'h304 + 32'(4 * i), 5'd1, 5'd2, 5'd3, 1, 1, 5'b00000, 3'b000, 3'b100);
            cyc(BUB, 0);
        end
        ex_flush = 1'b0;
        set_id(0, 32'h400, 5'd0, 5'd0, 5'd0, 0, 0, 5'b00000, 3'b000, 3'b000); cyc(CAP, 0);
        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", 160'(sbq.size()), 160'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
